// File: rtl/pipeline_hazard_controller.sv
// Hazard/flow controller for the five-stage RISC-V pipeline: load enables, NOP/flush
// steering, operand forwarding, RAM-wait freeze with watchdog, and a stall/flush counter.
module pipeline_hazard_controller #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic [4:0]       ID_rs1,
  input  logic [4:0]       ID_rs2,
  input  logic             ID_uses_rs1,
  input  logic             ID_uses_rs2,
  input  logic [4:0]       EX_rd,
  input  logic             EX_RF_enable,
  input  logic             EX_load_Instr,
  input  logic [4:0]       MEM_rd,
  input  logic             MEM_RF_enable,
  input  logic [4:0]       WB_rd,
  input  logic             WB_RF_enable,
  input  logic             EX_take_branch,
  input  logic             MEM_RAM_Enable,
  input  logic             mem_ready,
  output logic             PC_LE,
  output logic             IFID_LE,
  output logic             pipe_LE,
  output logic             nop_sel,
  output logic             IFID_flush,
  output logic             pc_sel,
  output logic [1:0]       fwdA,
  output logic [1:0]       fwdB,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_TIMEOUT  = 2'd2
  } state_t;

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  state_t           state_reg, state_next;
  logic [7:0]       wait_cnt_reg, wait_cnt_next;
  logic [CNT_W-1:0] stall_cnt_reg;

  logic [3:0]       fwd_all;   // {rs2 select, rs1 select}
  logic [1:0]       lu_op;     // per-operand load-use match
  logic             wait_req;
  logic             lu;
  logic             stall_event;

  // One identical forwarding/hazard slice per ID source operand.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_op
      logic [4:0] rs;
      logic       reads;
      logic [1:0] sel;

      assign rs    = (gi == 0) ? ID_rs1 : ID_rs2;
      assign reads = (gi == 0) ? ID_uses_rs1 : ID_uses_rs2;

      // A load in EX has no data yet, so it is skipped here and handled as load-use.
      always_comb begin
        sel = 2'b00;
        if (reads && rs != 5'd0) begin
          if (EX_RF_enable && !EX_load_Instr && EX_rd == rs)
            sel = 2'b01;
          else if (MEM_RF_enable && MEM_rd == rs)
            sel = 2'b10;
          else if (WB_RF_enable && WB_rd == rs)
            sel = 2'b11;
        end
      end

      assign lu_op[gi]            = reads && (rs != 5'd0) && EX_load_Instr &&
                                    EX_RF_enable && (EX_rd == rs);
      assign fwd_all[gi*2 +: 2]   = sel;
    end
  endgenerate

  assign wait_req = MEM_RAM_Enable & ~mem_ready;
  assign lu       = |lu_op;

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    PC_LE         = 1'b1;
    IFID_LE       = 1'b1;
    pipe_LE       = 1'b1;
    nop_sel       = 1'b0;
    IFID_flush    = 1'b0;
    pc_sel        = 1'b0;

    case (state_reg)
      ST_RUN: begin
        if (wait_req) begin
          PC_LE         = 1'b0;
          IFID_LE       = 1'b0;
          pipe_LE       = 1'b0;
          wait_cnt_next = 8'd1;
          state_next    = (MAX_WAIT_C <= 8'd1) ? ST_TIMEOUT : ST_MEM_WAIT;
        end else if (EX_take_branch) begin
          pc_sel     = 1'b1;
          IFID_flush = 1'b1;
          nop_sel    = 1'b1;
        end else if (lu) begin
          // Single bubble: next cycle the load sits in MEM and forwards from there.
          PC_LE   = 1'b0;
          IFID_LE = 1'b0;
          nop_sel = 1'b1;
        end
      end

      ST_MEM_WAIT: begin
        PC_LE   = 1'b0;
        IFID_LE = 1'b0;
        pipe_LE = 1'b0;
        if (mem_ready) begin
          state_next    = ST_RUN;
          wait_cnt_next = 8'd0;
        end else begin
          wait_cnt_next = wait_cnt_reg + 8'd1;
          if (wait_cnt_next >= MAX_WAIT_C)
            state_next = ST_TIMEOUT;
        end
      end

      ST_TIMEOUT: begin
        PC_LE   = 1'b0;
        IFID_LE = 1'b0;
        pipe_LE = 1'b0;
        nop_sel = 1'b1;
      end

      default: begin
        state_next = ST_RUN;
        PC_LE      = 1'b0;
        IFID_LE    = 1'b0;
        pipe_LE    = 1'b0;
        nop_sel    = 1'b1;
      end
    endcase

    // Reset overrides outputs immediately, not just at the next edge.
    if (Reset) begin
      PC_LE      = 1'b0;
      IFID_LE    = 1'b0;
      pipe_LE    = 1'b0;
      nop_sel    = 1'b1;
      IFID_flush = 1'b0;
      pc_sel     = 1'b0;
    end
  end

  assign fwdA        = Reset ? 2'b00 : fwd_all[1:0];
  assign fwdB        = Reset ? 2'b00 : fwd_all[3:2];
  assign mem_timeout = (state_reg == ST_TIMEOUT) & ~Reset;
  assign stall_cnt   = stall_cnt_reg;
  assign stall_event = ~PC_LE | IFID_flush | nop_sel;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_reg     <= ST_RUN;
      wait_cnt_reg  <= 8'd0;
      stall_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      if (stall_event && stall_cnt_reg != {CNT_W{1'b1}})
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller: a cycle-level behavioural model is
// compared on every falling edge, plus literal expectations at key scenario points.
module tb_pipeline_hazard_controller;

  localparam int MAX_WAIT  = 15;
  localparam int CNT_W     = 16;
  localparam int STALL_MAX = (1 << CNT_W) - 1;

  logic             clk, Reset;
  logic [4:0]       ID_rs1, ID_rs2, EX_rd, MEM_rd, WB_rd;
  logic             ID_uses_rs1, ID_uses_rs2, EX_RF_enable, EX_load_Instr;
  logic             MEM_RF_enable, WB_RF_enable, EX_take_branch, MEM_RAM_Enable, mem_ready;
  logic             PC_LE, IFID_LE, pipe_LE, nop_sel, IFID_flush, pc_sel, mem_timeout;
  logic [1:0]       fwdA, fwdB;
  logic [CNT_W-1:0] stall_cnt;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  pipeline_hazard_controller #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .Reset(Reset),
    .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_uses_rs1(ID_uses_rs1), .ID_uses_rs2(ID_uses_rs2),
    .EX_rd(EX_rd), .EX_RF_enable(EX_RF_enable), .EX_load_Instr(EX_load_Instr),
    .MEM_rd(MEM_rd), .MEM_RF_enable(MEM_RF_enable),
    .WB_rd(WB_rd), .WB_RF_enable(WB_RF_enable),
    .EX_take_branch(EX_take_branch), .MEM_RAM_Enable(MEM_RAM_Enable), .mem_ready(mem_ready),
    .PC_LE(PC_LE), .IFID_LE(IFID_LE), .pipe_LE(pipe_LE), .nop_sel(nop_sel),
    .IFID_flush(IFID_flush), .pc_sel(pc_sel), .fwdA(fwdA), .fwdB(fwdB),
    .mem_timeout(mem_timeout), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic pc, ifid, pipe, nop, flush, psel;
    logic [1:0] fa, fb;
  } exp_t;

  int m_mode;    // 0 flowing, 1 waiting on RAM, 2 timed out
  int m_waited;  // cycles spent waiting in the current RAM access
  int m_stalls;

  // Youngest writer wins; code is the 1-based position in the EX, MEM, WB list.
  function automatic logic [1:0] fwd_src(input logic [4:0] rs, input logic uses);
    logic [4:0] rd [3];
    logic       en [3];
    rd[0] = EX_rd;  en[0] = EX_RF_enable && !EX_load_Instr;
    rd[1] = MEM_rd; en[1] = MEM_RF_enable;
    rd[2] = WB_rd;  en[2] = WB_RF_enable;
    if (!uses || rs == 5'd0) return 2'b00;
    for (int k = 0; k < 3; k++)
      if (en[k] && rd[k] == rs) return 2'(k + 1);
    return 2'b00;
  endfunction

  function automatic exp_t expect_now();
    exp_t e;
    bit   lu;
    e = '0;
    e.pc = 1; e.ifid = 1; e.pipe = 1;
    e.fa = fwd_src(ID_rs1, ID_uses_rs1);
    e.fb = fwd_src(ID_rs2, ID_uses_rs2);
    lu = EX_load_Instr && EX_RF_enable && EX_rd != 0 &&
         ((ID_uses_rs1 && EX_rd == ID_rs1) || (ID_uses_rs2 && EX_rd == ID_rs2));
    if (Reset) begin
      e = '0; e.nop = 1;
    end else if (m_mode != 0) begin
      e.pc = 0; e.ifid = 0; e.pipe = 0; e.nop = (m_mode == 2);
    end else if (MEM_RAM_Enable && !mem_ready) begin
      e.pc = 0; e.ifid = 0; e.pipe = 0;
    end else if (EX_take_branch) begin
      e.psel = 1; e.flush = 1; e.nop = 1;
    end else if (lu) begin
      e.pc = 0; e.ifid = 0; e.nop = 1;
    end
    return e;
  endfunction

  always @(posedge clk or posedge Reset) begin
    exp_t e;
    if (Reset) begin
      m_mode <= 0; m_waited <= 0; m_stalls <= 0;
    end else begin
      e = expect_now();
      if ((!e.pc || e.flush || e.nop) && m_stalls < STALL_MAX)
        m_stalls <= m_stalls + 1;
      if (m_mode == 0 && MEM_RAM_Enable && !mem_ready) begin
        m_waited <= 1;
        m_mode   <= (1 >= MAX_WAIT) ? 2 : 1;
      end else if (m_mode == 1) begin
        if (mem_ready) m_mode <= 0;
        else begin
          m_waited <= m_waited + 1;
          if (m_waited + 1 >= MAX_WAIT) m_mode <= 2;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      exp_t e;
      e = expect_now();
      check("model PC_LE",      PC_LE,      e.pc);
      check("model IFID_LE",    IFID_LE,    e.ifid);
      check("model pipe_LE",    pipe_LE,    e.pipe);
      check("model nop_sel",    nop_sel,    e.nop);
      check("model IFID_flush", IFID_flush, e.flush);
      check("model pc_sel",     pc_sel,     e.psel);
      check("model fwdA",       fwdA,       e.fa);
      check("model fwdB",       fwdB,       e.fb);
      check("model stall_cnt",  stall_cnt,  m_stalls);
      check("model mem_timeout", mem_timeout, (m_mode == 2 && !Reset));
    end
  end

  // ---------------- stimulus ----------------
  task automatic clear_inputs();
    ID_rs1 = 0; ID_rs2 = 0; ID_uses_rs1 = 0; ID_uses_rs2 = 0;
    EX_rd = 0; EX_RF_enable = 0; EX_load_Instr = 0;
    MEM_rd = 0; MEM_RF_enable = 0; WB_rd = 0; WB_RF_enable = 0;
    EX_take_branch = 0; MEM_RAM_Enable = 0; mem_ready = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic at_neg();
    @(negedge clk); #1;
  endtask

  task automatic txn(input string what);
    $display("txn t=%0t %s stall_cnt=%0d", $time, what, stall_cnt);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    clk = 0; Reset = 1; clear_inputs(); chk_en = 1;
    tick(); tick();
    txn("reset held");
    check("rst PC_LE", PC_LE, 0);
    check("rst nop_sel", nop_sel, 1);
    check("rst stall_cnt", stall_cnt, 0);
    Reset = 0;

    at_neg();
    txn("idle flow");
    check("idle PC_LE", PC_LE, 1);
    check("idle nop_sel", nop_sel, 0);
    tick();

    // lw x5 in EX, add x6,x5,x1 in ID
    EX_rd = 5; EX_RF_enable = 1; EX_load_Instr = 1;
    ID_rs1 = 5; ID_uses_rs1 = 1; ID_rs2 = 1; ID_uses_rs2 = 1;
    at_neg();
    txn("load-use bubble");
    check("lu PC_LE", PC_LE, 0);
    check("lu IFID_LE", IFID_LE, 0);
    check("lu pipe_LE", pipe_LE, 1);
    check("lu nop_sel", nop_sel, 1);
    tick();
    EX_rd = 0; EX_RF_enable = 0; EX_load_Instr = 0;
    MEM_rd = 5; MEM_RF_enable = 1;
    at_neg();
    txn("load in MEM forwards");
    check("lu fwdA", fwdA, 2'b10);
    check("lu resume PC_LE", PC_LE, 1);
    check("lu stall_cnt", stall_cnt, 1);
    tick();

    // Forwarding priority on rs2
    EX_rd = 3; EX_RF_enable = 1; MEM_rd = 3; MEM_RF_enable = 1;
    ID_rs2 = 3; ID_uses_rs2 = 1;
    at_neg();
    txn("fwd EX over MEM");
    check("prio fwdB EX", fwdB, 2'b01);
    check("prio fwdA none", fwdA, 2'b00);
    tick();
    EX_rd = 0;
    at_neg();
    txn("fwd EX_rd=0 falls to MEM");
    check("prio fwdB MEM", fwdB, 2'b10);
    tick();
    MEM_RF_enable = 0; WB_rd = 7; WB_RF_enable = 1; ID_rs1 = 7;
    at_neg();
    txn("fwd from WB");
    check("wb fwdA", fwdA, 2'b11);
    tick();
    ID_uses_rs1 = 0;
    at_neg();
    check("unused rs1 fwdA", fwdA, 2'b00);
    tick();

    // Branch with simultaneous load-use
    clear_inputs();
    EX_rd = 5; EX_RF_enable = 1; EX_load_Instr = 1; EX_take_branch = 1;
    ID_rs1 = 5; ID_uses_rs1 = 1;
    at_neg();
    txn("branch beats load-use");
    check("br pc_sel", pc_sel, 1);
    check("br IFID_flush", IFID_flush, 1);
    check("br nop_sel", nop_sel, 1);
    check("br PC_LE", PC_LE, 1);
    tick();
    clear_inputs();
    at_neg();
    txn("after branch");
    check("br no extra stall", PC_LE, 1);
    check("br nop cleared", nop_sel, 0);
    check("br stall_cnt", stall_cnt, 2);
    tick();

    // RAM wait of 4 not-ready cycles, then ready
    MEM_RAM_Enable = 1; mem_ready = 0;
    at_neg();
    txn("ram wait start");
    check("wait pipe_LE", pipe_LE, 0);
    check("wait nop_sel", nop_sel, 0);
    tick();
    repeat (3) begin
      at_neg(); check("wait PC_LE", PC_LE, 0); tick();
    end
    mem_ready = 1;
    at_neg();
    check("ready still frozen", PC_LE, 0);
    tick();
    at_neg();
    txn("ram wait done");
    check("resume PC_LE", PC_LE, 1);
    check("resume mem_timeout", mem_timeout, 0);
    tick();

    // Asynchronous reset pulse in the middle of a RAM wait
    MEM_RAM_Enable = 1; mem_ready = 0; WB_rd = 7; WB_RF_enable = 1; ID_rs1 = 7; ID_uses_rs1 = 1;
    tick(); tick();
    #2 Reset = 1;
    #1;
    txn("async reset mid-wait");
    check("arst PC_LE", PC_LE, 0);
    check("arst nop_sel", nop_sel, 1);
    check("arst fwdA", fwdA, 2'b00);
    check("arst stall_cnt", stall_cnt, 0);
    #2 Reset = 0; MEM_RAM_Enable = 0;
    at_neg();
    check("arst run PC_LE", PC_LE, 1);
    check("arst run stall_cnt", stall_cnt, 0);
    tick();

    // Watchdog: mem_ready held low
    clear_inputs();
    MEM_RAM_Enable = 1; mem_ready = 0;
    repeat (14) tick();
    at_neg();
    txn("14 wait cycles elapsed");
    check("to not yet", mem_timeout, 0);
    tick();
    at_neg();
    txn("15 wait cycles elapsed");
    check("to set", mem_timeout, 1);
    check("to nop_sel", nop_sel, 1);
    tick();
    mem_ready = 1;
    tick();
    at_neg();
    check("to sticky", mem_timeout, 1);
    check("to frozen", PC_LE, 0);
    tick();
    Reset = 1;
    at_neg();
    check("to cleared by reset", mem_timeout, 0);
    Reset = 0; clear_inputs();
    tick();
    at_neg();
    txn("after timeout reset");
    check("to run again", PC_LE, 1);
    tick();

    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
